// File: rtl/fft_band_accum.sv
// fft_band_accum: sums the lower half of each FFT frame into equal-width bands, tracks the peak bin,
// and drains the band sums over a valid/ready stream.
module fft_band_accum #(
    parameter int DW = 32,
    parameter int FFT_LEN = 1024,
    parameter int USE_BINS = 512,
    parameter int NUM_BANDS = 16,
    localparam int BW = $clog2(USE_BINS / NUM_BANDS),
    localparam int SW = DW + BW,
    localparam int IW = $clog2(NUM_BANDS),
    localparam int LW = $clog2(FFT_LEN)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          mag_valid,
    input  logic          mag_sop,
    input  logic [DW-1:0] mag_data,
    output logic          band_valid,
    input  logic          band_ready,
    output logic [SW-1:0] band_data,
    output logic [IW-1:0] band_idx,
    output logic          band_last,
    output logic [LW-1:0] peak_bin,
    output logic [DW-1:0] peak_mag,
    output logic          frame_drop
);
    typedef enum logic [1:0] {ACCUM, DRAIN, SKIP} state_t;
    state_t state, state_nxt;
    logic [1:0] rst_sync;
    logic rst_i;
    logic [LW-1:0] bin_cnt, cur_bin, bin_nxt, wk_bin, wk_bin_nxt;
    logic [DW-1:0] wk_mag, wk_mag_nxt;
    logic [IW-1:0] k, band;
    logic [SW-1:0] acc [NUM_BANDS];
    logic [SW-1:0] acc_sum;
    logic take, in_use, first, last_bin, pk_upd, hs, drop;
    // reset asserts asynchronously but releases on a clock edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync <= '0;
        else rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_i = rst_sync[1];
    assign cur_bin = mag_sop ? '0 : bin_cnt;
    assign bin_nxt = mag_valid ? cur_bin + 1'b1 : bin_cnt;
    assign last_bin = &cur_bin;
    assign in_use = {1'b0, cur_bin} < (LW + 1)'(USE_BINS);
    assign band = IW'(cur_bin[LW-1:BW]);
    assign first = cur_bin[BW-1:0] == '0;
    // a sop seen while skipping is accepted immediately as bin 0 of the new frame
    assign take = mag_valid && (state == ACCUM || (state == SKIP && mag_sop));
    assign hs = state == DRAIN && band_ready;
    assign drop = mag_valid && ((state == ACCUM && mag_sop && bin_cnt != '0) || state == DRAIN);
    assign pk_upd = take && in_use && (cur_bin == LW'(1) || (cur_bin > LW'(1) && mag_data > wk_mag));
    assign wk_bin_nxt = pk_upd ? cur_bin : wk_bin;
    assign wk_mag_nxt = pk_upd ? mag_data : wk_mag;
    assign band_valid = state == DRAIN;
    assign band_data = acc[k];
    assign band_idx = k;
    assign band_last = band_valid && k == IW'(NUM_BANDS - 1);
    always_comb begin
        acc_sum = (first ? '0 : acc[band]) + SW'(mag_data);
        state_nxt = state;
        if (state == ACCUM && mag_valid && last_bin) state_nxt = DRAIN;
        if (state == SKIP && mag_valid && (mag_sop || last_bin)) state_nxt = ACCUM;
        if (hs && k == IW'(NUM_BANDS - 1)) state_nxt = bin_nxt == '0 ? ACCUM : SKIP;
    end
    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            state <= ACCUM;
            bin_cnt <= '0;
            k <= '0;
            wk_bin <= '0;
            wk_mag <= '0;
            peak_bin <= '0;
            peak_mag <= '0;
            frame_drop <= 1'b0;
            for (int i = 0; i < NUM_BANDS; i++) acc[i] <= '0;
        end else begin
            state <= state_nxt;
            bin_cnt <= bin_nxt;
            wk_bin <= wk_bin_nxt;
            wk_mag <= wk_mag_nxt;
            if (take && in_use) acc[band] <= acc_sum;
            if (take && last_bin) begin
                peak_bin <= wk_bin_nxt;
                peak_mag <= wk_mag_nxt;
            end
            if (hs) k <= k + 1'b1;
            if (drop) frame_drop <= 1'b1;
        end
    end
endmodule
